manchester_deserializer: RTL and testbench
==========================================

// Module: manchester_deserializer
// PURPOSE
//   Receive-side counterpart of the byte-wide Manchester transmit path. Samples
//   one Manchester chip per clock from serial_in and hunts for an encoded sync
//   byte to find the byte boundary. Once locked, decodes 16 chips into 8 data
//   bits and presents each byte on an AXI-Stream master. Used in the loopback
//   and link tests, in the same clock domain as the transmitter.
// PARAMETERS
//   SYNC_BYTE  8'hD5  frame delimiter; consumed by this block, never forwarded
//   ERR_CNT_W  16     width of the saturating code-error counter
// PORTS
//   clk            in   1          sole clock; all logic on the rising edge
//   rst            in   1          synchronous reset, active-high
//   serial_in      in   1          chip stream, one chip per clk
//   m_axis_tdata   out  8          decoded byte
//   m_axis_tvalid  out  1          byte available
//   m_axis_tready  in   1          downstream accepts
//   m_axis_tuser   out  1          1 = first byte after a sync
//   locked         out  1          1 in DATA state
//   overflow       out  1          sticky: a byte was dropped while the output was full
//   code_err_cnt   out  ERR_CNT_W  count of mid-byte invalid chip pairs; saturates
// BEHAVIOUR
//   - Chip coding: each bit is sent MSB first as a chip pair {b,~b}.
//     Bit 1 -> chips 1,0; bit 0 -> chips 0,1. Pairs 00 and 11 are invalid.
//   - Encoded sync: ENC(SYNC_BYTE) is 16 chips. ENC(8'hD5) = 16'b1010_0110_0110_0110,
//     first chip is the MSB.
//   - Reset: state=HUNT; tvalid=0, tuser=0, tdata=0, locked=0, overflow=0,
//     code_err_cnt=0. The 16-chip shift window is cleared to 0.
//   - HUNT:
//       - Every cycle, shift serial_in into a 16-chip window, newest chip at the LSB.
//       - When the window, including the chip sampled this cycle, equals ENC(SYNC_BYTE),
//         go to DATA on the next cycle. Set chip_idx=0 and first_flag=1.
//       - No bytes are emitted in HUNT.
//   - DATA:
//       - chip_idx counts 0..15. The pair (2k,2k+1) decodes bit 7-k.
//       - Pair is invalid and k==0 (first pair of a byte): end of frame, not an error.
//         Go to HUNT. The counter is unchanged.
//       - Pair is invalid and k>0: discard the partial byte, increment code_err_cnt
//         (saturate at all-ones), go to HUNT.
//       - Pair is checked on the cycle its 2nd chip is sampled. The transition takes
//         effect on the next cycle.
//       - After chip 15 is valid: the byte is complete. chip_idx wraps to 0 and the
//         block stays in DATA.
//   - Output register, one entry:
//       - A completed byte sampled on cycle N drives tvalid=1 on cycle N+1.
//         tuser=first_flag, which then clears.
//       - tdata and tuser hold stable while tvalid && !tready.
//       - tvalid drops after the handshake cycle unless a new byte loads that same
//         cycle. A simultaneous handshake and load is legal and back-to-back.
//       - Byte completes while the register is full and not being handshaken:
//         drop the new byte, set overflow (sticky until rst), keep the held byte.
//   - locked=1 exactly while in DATA.
//   - Reset mid-operation:
//       - Aborts any byte and drops a pending tvalid the next cycle.
//       - The first data byte after reset always requires a fresh sync.
//   - Sustained throughput: 1 byte / 16 clk. tready low for up to 15 cycles loses no data.
// TESTING
//   - Idle low 40 clk, then ENC(D5), ENC(3C), ENC(A5), idle -> bytes 3C(tuser=1) and
//     A5(tuser=0). Each tvalid comes 1 clk after the byte's last chip. Then locked=0,
//     code_err_cnt=0.
//   - ENC(D5) shifted by 1 chip amid random data is detected once. ENC(D5) appearing
//     inside a payload while in DATA is decoded as data byte D5, not as a re-sync.
//   - After sync, send chips 10 10 11 ... mid-byte -> no output, code_err_cnt=1,
//     locked=0. Next sync+ENC(55) -> 55 with tuser=1.
//   - Hold tready=0 across two completed bytes 11, 22 -> 11 held, 22 dropped,
//     overflow=1. Raise tready -> 11 accepted, tvalid=0.
//   - tready=1 constantly with 64-byte frame -> 64 beats, 16 clk apart, data matches.
//   - Assert rst for 1 clk at chip 9 of a byte -> no partial byte emitted, tvalid=0,
//     counters 0. Relock only on next sync.

Source files
------------

// File: rtl/manchester_deserializer.sv
// Manchester chip-stream receiver: hunts for the encoded sync byte, then decodes
// 16 chips per byte and presents bytes on a single-entry AXI-Stream output register.
module manchester_deserializer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hD5,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tuser,
  output logic                 locked,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] code_err_cnt
);

  localparam int unsigned CHIPS_PER_BYTE = 16;
  localparam int unsigned IDX_W          = $clog2(CHIPS_PER_BYTE);

  // Bit b maps to chip pair {b,~b}, MSB first; first chip lands in the MSB.
  function automatic logic [CHIPS_PER_BYTE-1:0] manch_enc(input logic [7:0] b);
    logic [CHIPS_PER_BYTE-1:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e[2*i+1] = b[i];
      e[2*i]   = ~b[i];
    end
    return e;
  endfunction

  localparam logic [CHIPS_PER_BYTE-1:0] ENC_SYNC = manch_enc(SYNC_BYTE);

  typedef enum logic {
    S_HUNT = 1'b0,
    S_DATA = 1'b1
  } state_e;

  state_e                   state_q;
  logic [CHIPS_PER_BYTE-2:0] window_q;
  logic [IDX_W-1:0]         chip_idx_q;
  logic                     chip0_q;
  logic [6:0]               byte_q;
  logic                     first_q;
  logic [7:0]               tdata_q;
  logic                     tvalid_q;
  logic                     tuser_q;
  logic                     overflow_q;
  logic [ERR_CNT_W-1:0]     err_cnt_q;

  logic [CHIPS_PER_BYTE-1:0] window_d;
  logic [7:0]                byte_d;
  logic                      pair_ok;
  logic                      byte_done;

  // Current chip completes the window / pair; decisions are made on it directly.
  assign window_d  = {window_q, serial_in};
  assign byte_d    = {byte_q, chip0_q};
  assign pair_ok   = chip0_q ^ serial_in;
  assign byte_done = (state_q == S_DATA) && (chip_idx_q == IDX_W'(CHIPS_PER_BYTE - 1)) && pair_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HUNT;
      window_q   <= '0;
      chip_idx_q <= '0;
      chip0_q    <= 1'b0;
      byte_q     <= '0;
      first_q    <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_HUNT: begin
          window_q <= window_d[CHIPS_PER_BYTE-2:0];
          if (window_d == ENC_SYNC) begin
            state_q    <= S_DATA;
            chip_idx_q <= '0;
            first_q    <= 1'b1;
          end
        end
        S_DATA: begin
          // Window restarts empty so a later sync needs 16 fresh chips.
          window_q   <= '0;
          chip_idx_q <= chip_idx_q + IDX_W'(1);
          if (!chip_idx_q[0]) begin
            chip0_q <= serial_in;
          end else if (!pair_ok) begin
            // Invalid first pair is a normal end of frame, not a code error.
            if ((chip_idx_q[IDX_W-1:1] != '0) && (err_cnt_q != '1)) begin
              err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
            state_q <= S_HUNT;
          end else begin
            byte_q <= byte_d[6:0];
          end
        end
        default: state_q <= S_HUNT;
      endcase

      // Single-entry output register; a full, stalled register drops the new byte.
      if (byte_done) begin
        first_q <= 1'b0;
        if (!tvalid_q || m_axis_tready) begin
          tdata_q  <= byte_d;
          tuser_q  <= first_q;
          tvalid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign locked        = (state_q == S_DATA);
  assign overflow      = overflow_q;
  assign code_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_manchester_deserializer.sv
// Bench for manchester_deserializer: chip streams built from bytes, expected beats
// derived by scanning each stream for the sync pattern and decoding pair by pair.
module tb_manchester_deserializer;

  localparam logic [15:0] ENC_D5 = 16'b1010_0110_0110_0110;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_in;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        locked;
  logic        overflow;
  logic [15:0] code_err_cnt;

  manchester_deserializer #(.SYNC_BYTE(8'hD5), .ERR_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .locked       (locked),
    .overflow     (overflow),
    .code_err_cnt (code_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       u;
    int         t;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  int    exp_err = 0;
  int    model_nb = 0;
  logic  rdy = 1'b1;
  bit    stim[$];
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void add_chip(input bit c);
    stim.push_back(c);
  endfunction

  function automatic void add_zeros(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'b0);
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      stim.push_back(b[i]);
      stim.push_back(!b[i]);
    end
  endfunction

  function automatic void add_sync();
    logic [15:0] s;
    s = ENC_D5;
    for (int i = 15; i >= 0; i--) stim.push_back(s[i]);
  endfunction

  // Expected beats of the stream in stim, assuming the receiver starts hunting.
  function automatic void model(input int base, input int keep, output int errs);
    int n;
    int p;
    n = stim.size();
    p = 0;
    errs = 0;
    model_nb = 0;
    while (p + 15 < n) begin
      int e;
      int pos;
      bit first;
      bit in_frame;
      logic [7:0] v;
      e = -1;
      for (int j = p + 15; j < n; j++) begin
        logic [15:0] w;
        for (int m = 0; m < 16; m++) w[15-m] = stim[j-15+m];
        if (w == ENC_D5) begin
          e = j;
          break;
        end
      end
      if (e < 0) break;
      pos = e + 1;
      first = 1'b1;
      p = n;
      in_frame = 1'b1;
      v = '0;
      while (in_frame) begin
        int k;
        k = 0;
        while (k < 8) begin
          if (pos + 2*k + 1 >= n) begin
            in_frame = 1'b0;
            break;
          end
          if (stim[pos+2*k] == stim[pos+2*k+1]) begin
            if (k > 0) errs++;
            p = pos + 2*k + 2;
            in_frame = 1'b0;
            break;
          end
          v[7-k] = stim[pos+2*k];
          k++;
        end
        if (k == 8) begin
          if (keep < 0 || model_nb < keep) exp_q.push_back('{d: v, u: first, t: base + pos + 15});
          model_nb++;
          first = 1'b0;
          pos += 16;
        end
      end
    end
  endfunction

  // One chip per clock; outputs sampled on the falling edge.
  task automatic step(input bit c);
    logic hs;
    logic was;
    beat_t b;
    cyc++;
    serial_in = c;
    m_axis_tready = rdy;
    hs  = m_axis_tvalid && m_axis_tready;
    was = m_axis_tvalid;
    @(posedge clk);
    @(negedge clk);
    if (m_axis_tvalid === 1'b1 && (was !== 1'b1 || hs === 1'b1)) begin
      beats_seen++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed data=0x%0h expected no beat", m_axis_tdata);
      end
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("beat_data", 32'(m_axis_tdata), 32'(b.d));
        chk("beat_tuser", 32'(m_axis_tuser), 32'(b.u));
        chk("beat_cycle", 32'(cyc), 32'(b.t));
      end
    end
  endtask

  task automatic run_seg(input int keep, input int rst_at);
    int errs;
    model(cyc + 1, keep, errs);
    exp_err += errs;
    for (int i = 0; i < stim.size(); i++) begin
      rst = (i == rst_at);
      step(stim[i]);
    end
    rst = 1'b0;
    chk("missing_beats", 32'(exp_q.size()), 32'd0);
    if (rst_at < 0) chk("code_err_cnt", 32'(code_err_cnt), 32'(exp_err));
    exp_q.delete();
    stim.delete();
  endtask

  initial begin
    int b0;
    int nb;
    rst = 1'b1;
    serial_in = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err", 32'(code_err_cnt), 32'd0);
    rst = 1'b0;

    // Basic frame after idle
    add_zeros(40); add_sync(); add_byte(8'h3C); add_byte(8'hA5); add_zeros(16);
    b0 = beats_seen;
    run_seg(-1, -1);
    chk("t1_beats", 32'(beats_seen - b0), 32'd2);
    chk("t1_locked", 32'(locked), 32'd0);
    chk("t1_err", 32'(code_err_cnt), 32'd0);

    // Sync misaligned by one chip amid random data; D5 as payload
    for (int i = 0; i < 3; i++) add_byte(8'($urandom));
    add_chip(1'($urandom % 2));
    add_sync();
    add_byte(8'($urandom)); add_byte(8'hD5); add_byte(8'($urandom)); add_byte(8'($urandom));
    add_zeros(16);
    b0 = beats_seen;
    run_seg(-1, -1);
    nb = model_nb;
    chk("t2_beats", 32'(beats_seen - b0), 32'(nb));

    // Mid-byte code error, then recovery
    add_sync();
    add_chip(1'b1); add_chip(1'b0); add_chip(1'b1); add_chip(1'b0); add_chip(1'b1); add_chip(1'b1);
    add_zeros(16);
    b0 = beats_seen;
    run_seg(-1, -1);
    chk("t3_beats", 32'(beats_seen - b0), 32'd0);
    chk("t3_err", 32'(code_err_cnt), 32'd1);
    chk("t3_locked", 32'(locked), 32'd0);
    add_zeros(4); add_sync(); add_byte(8'h55); add_zeros(16);
    run_seg(-1, -1);

    // Stalled output: second byte dropped
    rdy = 1'b0;
    add_sync(); add_byte(8'h11); add_byte(8'h22); add_zeros(16);
    run_seg(1, -1);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    chk("t4_tdata_held", 32'(m_axis_tdata), 32'h11);
    rdy = 1'b1;
    step(1'b0);
    chk("t4_tvalid_after_hs", 32'(m_axis_tvalid), 32'd0);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Long frame at full rate
    add_sync();
    for (int i = 0; i < 64; i++) add_byte(8'($urandom));
    add_zeros(16);
    b0 = beats_seen;
    run_seg(-1, -1);
    chk("t5_beats", 32'(beats_seen - b0), 32'd64);

    // Reset at chip 9 of a byte with a pending beat
    rdy = 1'b0;
    add_sync(); add_byte(8'h99); add_byte(8'h0F);
    for (int i = 0; i < 6; i++) void'(stim.pop_back());
    run_seg(-1, stim.size() - 1);
    exp_err = 0;
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_err", 32'(code_err_cnt), 32'd0);
    rdy = 1'b1;
    add_byte(8'h0F); add_byte(8'h3C); add_zeros(16);
    b0 = beats_seen;
    run_seg(-1, -1);
    chk("t6_no_relock", 32'(beats_seen - b0), 32'd0);
    add_sync(); add_byte(8'h77); add_zeros(16);
    b0 = beats_seen;
    run_seg(-1, -1);
    chk("t6_relock_beats", 32'(beats_seen - b0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
